traffic_phase_ctrl: RTL

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

---
 rtl/traffic_pkg.sv | 49 ++++
 rtl/phase_timer.sv | 53 +++++
 rtl/traffic_phase_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic phase controller:
//   - phase_e    : state encoding, also driven out on the phase port
//   - RED/YELLOW/GREEN/OFF : lamp triplets, bit order {red,yellow,green}
//   - main_lamps / cross_lamps : Moore decode of a state plus flash phase
// -----------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_MG    = 3'd0,
    ST_MY    = 3'd1,
    ST_AR1   = 3'd2,
    ST_CG    = 3'd3,
    ST_CY    = 3'd4,
    ST_AR2   = 3'd5,
    ST_FLASH = 3'd6
  } phase_e;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] OFF    = 3'b000;

  // Main-road lamps for a given state; lit selects the on half of the flash.
  function automatic logic [2:0] main_lamps(input phase_e st, input logic lit);
    logic [2:0] l;
    case (st)
      ST_MG:    l = GREEN;
      ST_MY:    l = YELLOW;
      ST_FLASH: l = lit ? YELLOW : OFF;
      default:  l = RED;
    endcase
    return l;
  endfunction

  // Cross-road lamps for a given state; lit selects the on half of the flash.
  function automatic logic [2:0] cross_lamps(input phase_e st, input logic lit);
    logic [2:0] l;
    case (st)
      ST_CG:    l = GREEN;
      ST_CY:    l = YELLOW;
      ST_FLASH: l = lit ? RED : OFF;
      default:  l = RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Per-phase elapsed-time counter. Clears on clear_i, otherwise counts up one
// per clock and sticks at all-ones. done_o is high once the count has reached
// dur_i-1, i.e. on the last cycle of a phase lasting dur_i cycles.
// Ports:
//   clk_1Hz  in   phase clock
//   reset    in   asynchronous, active-high reset
//   clear_i  in   restart the count (state is changing this edge)
//   dur_i    in   duration of the current phase in cycles (>= 1)
//   done_o   out  count >= dur_i-1
// -----------------------------------------------------------------------------
module phase_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk_1Hz,
  input  logic             reset,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] dur_i,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear, saturate, or increment.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = {CNT_W{1'b0}};
    end else if (count_q == CNT_MAX) begin
      count_d = count_q;
    end else begin
      count_d = count_q + CNT_ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  // >= rather than == so a held phase (main green) stays done while saturated.
  assign done_o = (count_q >= (dur_i - CNT_ONE));

endmodule

// File: rtl/traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_phase_ctrl
// Two-road intersection controller: main green held until a cross request or
// night mode arrives, then yellow, all-red, and either the cross-road cycle or
// flashing mode. Lamp outputs are registered and decoded from the next state
// so they change on the same edge as the state register.
// Ports:
//   clk_1Hz      in   phase clock, rising edge
//   reset        in   asynchronous, active-high reset
//   cross_req    in   cross-road request, sampled every edge
//   night_mode   in   flashing-mode request, sampled every edge
//   main_st      out  main lamps {red,yellow,green}
//   cross_st     out  cross lamps {red,yellow,green}
//   req_pending  out  latched cross request
//   phase        out  current state encoding (traffic_pkg::phase_e)
// -----------------------------------------------------------------------------
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int MAIN_GREEN_S  = 15,
  parameter int YELLOW_S      = 3,
  parameter int CROSS_GREEN_S = 10,
  parameter int ALL_RED_S     = 1,
  parameter int CNT_W         = 5
) (
  input  logic       clk_1Hz,
  input  logic       reset,
  input  logic       cross_req,
  input  logic       night_mode,
  output logic [2:0] main_st,
  output logic [2:0] cross_st,
  output logic       req_pending,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] DUR_MG = CNT_W'(MAIN_GREEN_S);
  localparam logic [CNT_W-1:0] DUR_Y  = CNT_W'(YELLOW_S);
  localparam logic [CNT_W-1:0] DUR_CG = CNT_W'(CROSS_GREEN_S);
  localparam logic [CNT_W-1:0] DUR_AR = CNT_W'(ALL_RED_S);

  phase_e           state_q, state_d;
  logic             req_q, req_d;
  logic             night_cause_q, night_cause_d;  // MY entry was night-caused
  logic             flash_lit_q, flash_lit_d;
  logic [2:0]       main_q, cross_q;
  logic [CNT_W-1:0] dur_s;
  logic             done_s;
  logic             clear_s;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_1Hz (clk_1Hz),
    .reset   (reset),
    .clear_i (clear_s),
    .dur_i   (dur_s),
    .done_o  (done_s)
  );

  // Next-state, phase duration, and flash/request bookkeeping.
  always_comb begin
    state_d       = state_q;
    night_cause_d = night_cause_q;
    dur_s         = DUR_AR;
    case (state_q)
      ST_MG: begin
        dur_s = DUR_MG;
        if (done_s && (req_q || night_mode)) begin
          state_d       = ST_MY;
          night_cause_d = night_mode;  // night wins when both are present
        end else begin
          state_d = ST_MG;
        end
      end
      ST_MY: begin
        dur_s = DUR_Y;
        if (done_s) state_d = ST_AR1;
        else        state_d = ST_MY;
      end
      ST_AR1: begin
        dur_s = DUR_AR;
        if (done_s) state_d = night_cause_q ? ST_FLASH : ST_CG;
        else        state_d = ST_AR1;
      end
      ST_CG: begin
        dur_s = DUR_CG;
        if (done_s) state_d = ST_CY;
        else        state_d = ST_CG;
      end
      ST_CY: begin
        dur_s = DUR_Y;
        if (done_s) state_d = ST_AR2;
        else        state_d = ST_CY;
      end
      ST_AR2: begin
        dur_s = DUR_AR;
        if (done_s) state_d = ST_MG;
        else        state_d = ST_AR2;
      end
      ST_FLASH: begin
        dur_s = DUR_AR;
        if (!night_mode) state_d = ST_AR2;
        else             state_d = ST_FLASH;
      end
      default: begin
        state_d       = ST_MG;
        night_cause_d = 1'b0;
      end
    endcase

    clear_s = (state_d != state_q);

    // Flash starts lit on entry and toggles every cycle while staying.
    if ((state_q == ST_FLASH) && (state_d == ST_FLASH)) begin
      flash_lit_d = ~flash_lit_q;
    end else begin
      flash_lit_d = 1'b1;
    end

    // Entering CG serves the request; this takes priority over a new sample.
    if ((state_q == ST_AR1) && (state_d == ST_CG)) begin
      req_d = 1'b0;
    end else if (cross_req && (state_q != ST_CG)) begin
      req_d = 1'b1;
    end else begin
      req_d = req_q;
    end
  end

  // State, request latch and registered lamp outputs.
  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      state_q       <= ST_MG;
      req_q         <= 1'b0;
      night_cause_q <= 1'b0;
      flash_lit_q   <= 1'b1;
      main_q        <= GREEN;
      cross_q       <= RED;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      night_cause_q <= night_cause_d;
      flash_lit_q   <= flash_lit_d;
      main_q        <= main_lamps(state_d, flash_lit_d);
      cross_q       <= cross_lamps(state_d, flash_lit_d);
    end
  end

  assign main_st     = main_q;
  assign cross_st    = cross_q;
  assign req_pending = req_q;
  assign phase       = state_q;

endmodule
